// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, default widths and the timeout counter sizing helper.
package apb_pkg;

   localparam int APB_ADDR_WIDTH     = 32;
   localparam int APB_DATA_WIDTH     = 32;
   localparam int APB_STB_WIDTH      = 4;
   localparam int APB_TIMEOUT_CYCLES = 255;
   localparam logic [31:0] APB_UART_ADDR = 32'h0100_0000;

   typedef enum logic [1:0] {
      APB_IDLE   = 2'd0,
      APB_SETUP  = 2'd1,
      APB_ACCESS = 2'd2
   } apb_state_e;

   // Counter width able to hold the timeout value; at least one bit so 0 and 1 still build.
   function automatic int apb_cnt_width(input int cycles);
      if (cycles > 1) begin
         return $clog2(cycles + 1);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/apb_initiator_if.sv
// CPU request/response port plus APB bus signals of the initiator, with initiator and target views.
interface apb_initiator_if
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
   parameter int DATA_WIDTH = APB_DATA_WIDTH
);
   logic                     req_valid;
   logic                     req_ready;
   logic [ADDR_WIDTH-1:0]    req_addr;
   logic [DATA_WIDTH-1:0]    req_wdata;
   logic [APB_STB_WIDTH-1:0] req_wstb;
   logic                     req_write;
   logic                     rsp_valid;
   logic [DATA_WIDTH-1:0]    rsp_rdata;
   logic                     rsp_err;
   logic [ADDR_WIDTH-1:0]    paddr;
   logic [DATA_WIDTH-1:0]    pdata;
   logic                     pwrite;
   logic [APB_STB_WIDTH-1:0] pstb;
   logic                     psel;
   logic                     penable;
   logic [DATA_WIDTH-1:0]    prdata;
   logic                     pready;
   logic                     perr;

   modport master (
      input  req_valid, req_addr, req_wdata, req_wstb, req_write, prdata, pready, perr,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, paddr, pdata, pwrite, pstb, psel, penable
   );

   modport slave (
      output req_valid, req_addr, req_wdata, req_wstb, req_write, prdata, pready, perr,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, paddr, pdata, pwrite, pstb, psel, penable
   );

endinterface

// File: rtl/apb_timeout.sv
// Loadable saturating down-counter; expired pulses on the enabled cycle that takes it from 1 to 0.
module apb_timeout #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             enable,
   output logic             expired
);

   logic [WIDTH-1:0] count_r;

   // Count register; a load value of 0 never expires because the count saturates at 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= {WIDTH{1'b0}};
      end else if (clear) begin
         count_r <= {WIDTH{1'b0}};
      end else if (load) begin
         count_r <= load_value;
      end else if (enable && (count_r != {WIDTH{1'b0}})) begin
         count_r <= count_r - WIDTH'(1);
      end
   end

   assign expired = enable && (count_r == WIDTH'(1));

endmodule

// File: rtl/apb_initiator.sv
// APB requester: turns a single-beat CPU request into SETUP/ACCESS phases and returns a one-cycle response.
module apb_initiator
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
   parameter int DATA_WIDTH     = APB_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
   input  logic          pclk,
   input  logic          presetn,
   apb_initiator_if.master bus
);

   localparam int TO_W = apb_cnt_width(TIMEOUT_CYCLES);

   apb_state_e               state_r, next_state_s;
   logic                     accept_s, done_s, timeout_s, expired_s;
   logic                     to_clear_s, to_load_s, to_enable_s;
   logic                     req_ready_r, psel_r, penable_r, pwrite_r;
   logic                     rsp_valid_r, rsp_err_r;
   logic [DATA_WIDTH-1:0]    rsp_rdata_r, pdata_r;
   logic [ADDR_WIDTH-1:0]    paddr_r;
   logic [APB_STB_WIDTH-1:0] pstb_r;

   // Timer is armed during SETUP so it starts from TIMEOUT_CYCLES on the first ACCESS cycle.
   assign to_clear_s  = (state_r == APB_IDLE);
   assign to_load_s   = (state_r == APB_SETUP);
   assign to_enable_s = (state_r == APB_ACCESS) && !bus.pready;

   apb_timeout #(.WIDTH(TO_W)) u_timeout (
      .clk        (pclk),
      .rst_n      (presetn),
      .clear      (to_clear_s),
      .load       (to_load_s),
      .load_value (TO_W'(TIMEOUT_CYCLES)),
      .enable     (to_enable_s),
      .expired    (expired_s)
   );

   // State register.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_r <= APB_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state decode; pready is checked before expiry so a ready slave wins the tie.
   always_comb begin
      next_state_s = state_r;
      accept_s     = 1'b0;
      done_s       = 1'b0;
      timeout_s    = 1'b0;
      case (state_r)
         APB_IDLE: begin
            if (bus.req_valid) begin
               accept_s     = 1'b1;
               next_state_s = APB_SETUP;
            end else begin
               next_state_s = APB_IDLE;
            end
         end
         APB_SETUP: begin
            next_state_s = APB_ACCESS;
         end
         APB_ACCESS: begin
            if (bus.pready) begin
               done_s       = 1'b1;
               next_state_s = APB_IDLE;
            end else if (expired_s) begin
               timeout_s    = 1'b1;
               next_state_s = APB_IDLE;
            end else begin
               next_state_s = APB_ACCESS;
            end
         end
         default: begin
            next_state_s = APB_IDLE;
         end
      endcase
   end

   // Phase outputs registered from the next state so they line up with state_r.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         req_ready_r <= 1'b1;
         psel_r      <= 1'b0;
         penable_r   <= 1'b0;
      end else begin
         req_ready_r <= (next_state_s == APB_IDLE);
         psel_r      <= (next_state_s != APB_IDLE);
         penable_r   <= (next_state_s == APB_ACCESS);
      end
   end

   // Request capture; values hold through the transfer and afterwards until the next accept.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         paddr_r  <= {ADDR_WIDTH{1'b0}};
         pdata_r  <= {DATA_WIDTH{1'b0}};
         pwrite_r <= 1'b0;
         pstb_r   <= {APB_STB_WIDTH{1'b0}};
      end else if (accept_s) begin
         paddr_r  <= bus.req_addr;
         pdata_r  <= bus.req_wdata;
         pwrite_r <= bus.req_write;
         pstb_r   <= bus.req_write ? bus.req_wstb : {APB_STB_WIDTH{1'b0}};
      end
   end

   // Response: one-cycle valid pulse, data and error held until the next completion.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         rsp_valid_r <= 1'b0;
         rsp_err_r   <= 1'b0;
         rsp_rdata_r <= {DATA_WIDTH{1'b0}};
      end else begin
         rsp_valid_r <= done_s || timeout_s;
         if (done_s) begin
            rsp_err_r   <= bus.perr;
            rsp_rdata_r <= pwrite_r ? {DATA_WIDTH{1'b0}} : bus.prdata;
         end else if (timeout_s) begin
            rsp_err_r   <= 1'b1;
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
         end
      end
   end

   assign bus.req_ready = req_ready_r;
   assign bus.psel      = psel_r;
   assign bus.penable   = penable_r;
   assign bus.paddr     = paddr_r;
   assign bus.pdata     = pdata_r;
   assign bus.pwrite    = pwrite_r;
   assign bus.pstb      = pstb_r;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_err   = rsp_err_r;
   assign bus.rsp_rdata = rsp_rdata_r;

endmodule
